// File: rtl/pio_led_fader.sv
// ============================================================================
// pio_led_fader : per-bit PWM LED drive that ramps between off and full on.
// Revision 1.0
// ============================================================================
`default_nettype none

module pio_led_fader #(
  parameter int N_LED     = 8,
  parameter int PWM_BITS  = 8,
  parameter int STEP_DIV  = 1024,
  parameter int FADE_STEP = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_LED-1:0] in_port,
  input  logic             enable,
  input  logic             fade_bypass,
  output logic [N_LED-1:0] led_out,
  output logic             busy
);

  localparam int                  c_pre_w    = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [PWM_BITS-1:0] c_max      = {PWM_BITS{1'b1}};
  localparam logic [PWM_BITS-1:0] c_pwm_one  = PWM_BITS'(1);
  localparam logic [c_pre_w-1:0]  c_pre_last = c_pre_w'(STEP_DIV - 1);
  localparam logic [c_pre_w-1:0]  c_pre_one  = c_pre_w'(1);
  localparam logic [PWM_BITS:0]   c_step     = (PWM_BITS + 1)'(FADE_STEP);
  localparam logic [PWM_BITS:0]   c_max_wide = {1'b0, c_max};

  logic [PWM_BITS-1:0]             pwm_cnt_q, pwm_cnt_d;
  logic [c_pre_w-1:0]              pre_cnt_q, pre_cnt_d;
  logic [N_LED-1:0]                in_reg_q, in_reg_d;
  logic [N_LED-1:0][PWM_BITS-1:0]  lvl_q, lvl_d;
  logic [N_LED-1:0]                led_out_q, led_out_d;
  logic                            w_step_tick;
  logic                            w_busy;

  always_comb begin
    w_step_tick = (pre_cnt_q == c_pre_last);
    pre_cnt_d   = w_step_tick ? '0 : pre_cnt_q + c_pre_one;
    pwm_cnt_d   = pwm_cnt_q + c_pwm_one;
    in_reg_d    = in_port;
  end

  // Up/down arithmetic is one bit wider so the clamps see the true result.
  always_comb begin
    logic [PWM_BITS-1:0] tgt;
    logic [PWM_BITS:0]   up;
    logic [PWM_BITS:0]   cur;
    lvl_d     = lvl_q;
    led_out_d = '0;
    w_busy    = 1'b0;
    tgt       = '0;
    up        = '0;
    cur       = '0;
    for (int i = 0; i < N_LED; i++) begin
      tgt = in_reg_q[i] ? c_max : '0;
      cur = {1'b0, lvl_q[i]};
      up  = cur + c_step;
      if (fade_bypass) begin
        lvl_d[i] = tgt;
      end else if (w_step_tick && (lvl_q[i] < tgt)) begin
        lvl_d[i] = (up > c_max_wide) ? c_max : up[PWM_BITS-1:0];
      end else if (w_step_tick && (lvl_q[i] > tgt)) begin
        lvl_d[i] = (cur >= c_step) ? lvl_q[i] - c_step[PWM_BITS-1:0] : '0;
      end
      led_out_d[i] = enable & ((lvl_q[i] == c_max) | (lvl_q[i] > pwm_cnt_q));
      w_busy       = w_busy | (lvl_q[i] != tgt);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pwm_cnt_q <= '0;
      pre_cnt_q <= '0;
      in_reg_q  <= '0;
      lvl_q     <= '0;
      led_out_q <= '0;
    end else begin
      pwm_cnt_q <= pwm_cnt_d;
      pre_cnt_q <= pre_cnt_d;
      in_reg_q  <= in_reg_d;
      lvl_q     <= lvl_d;
      led_out_q <= led_out_d;
    end
  end

  assign led_out = led_out_q;
  assign busy    = w_busy;

endmodule

`default_nettype wire

// File: doc/pio_led_fader.md
Name: pio_led_fader

Overview:
- Downstream consumer of the system's 8-bit PIO output port.
- Turns each on/off bit from the CPU into a PWM LED drive that ramps smoothly between off and full brightness, rather than switching abruptly.
- Sits between the PIO out_port and the DE10-Nano LED pins.
- Gives software a "busy" status, so firmware can see when all fades have completed.

Parameters:
- N_LED, 8, number of LED channels; equals the PIO output width.
- PWM_BITS, 8, width of the PWM counter and of each brightness level; MAX = 2^PWM_BITS-1.
- STEP_DIV, 1024, clk cycles per fade step (must be >= 1).
- FADE_STEP, 4, brightness change applied per fade step (1..MAX).

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- in_port  input  N_LED  on/off request per LED; connects to PIO out_port.
- enable  input  1  1 = drive LEDs; 0 = force all LEDs off while levels hold.
- fade_bypass  input  1  1 = levels jump directly to target (no ramp).
- led_out  output  N_LED  registered PWM drive, 1 = LED lit.
- busy  output  1  1 while any level differs from its target.

Behaviour:
- Single clock domain; all state is on the rising edge of clk.
- Async reset clears everything: pwm_cnt=0, pre_cnt=0, in_reg=0, every lvl[i]=0, led_out=0, busy=0.
- Input stage: in_reg <= in_port every cycle, with one cycle of latency. The target for LED i is tgt[i] = in_reg[i] ? MAX : 0.
- PWM counter pwm_cnt (PWM_BITS):
  - Free-running increment, wrapping from MAX to 0.
  - Runs regardless of enable.
- Prescaler pre_cnt (clog2(STEP_DIV) bits):
  - Counts 0..STEP_DIV-1 and then wraps.
  - step_tick=1 in the cycle where pre_cnt==STEP_DIV-1.
  - Runs regardless of enable.
- Level update, per LED, with priority top-down:
  - fade_bypass=1: lvl[i] <= tgt[i] the next edge.
  - step_tick=1 and lvl[i] < tgt[i]: lvl[i] <= min(lvl[i]+FADE_STEP, MAX). The sum is computed one bit wider, so there is no wrap-around.
  - step_tick=1 and lvl[i] > tgt[i]: lvl[i] <= max(lvl[i]-FADE_STEP, 0). The difference is signed/wider, so there is no underflow.
  - Otherwise lvl[i] holds.
- Target reversal mid-fade: the ramp reverses from the current level on the next step_tick; no restart from an endpoint.
- Output:
  - led_out[i] <= enable & ((lvl[i]==MAX) | (lvl[i] > pwm_cnt)).
  - This gives lvl=0 fully off, lvl=MAX fully on, and otherwise a duty of lvl/2^PWM_BITS.
- busy: combinational OR over i of (lvl[i] != tgt[i]). It rises one cycle after an in_port change (the in_reg latency).
- enable=0:
  - led_out is 0 from the next edge.
  - Levels still ramp toward their targets.
  - Re-enable shows the current level immediately.
- fade_bypass latency: in_port change at edge n -> in_reg at n+1 -> lvl at n+2 -> led_out at n+3.
- Ramp duration from 0 to MAX is ceil(MAX/FADE_STEP) step_ticks.
- Simultaneous in_port change and step_tick: the step uses the previous in_reg; the new target applies from the following tick.
- Reset mid-fade: all levels snap to 0 and the outputs go low asynchronously.

Test Plan (PWM_BITS=8, STEP_DIV=4, FADE_STEP=64 unless stated):
1. Reset:
   - Stimulus: assert reset while in_port=8'hFF, enable=1.
   - Required: led_out=0, busy=0 during reset.
   - After release, busy=1 at the second edge and lvl[0] walks 0->64->128->192->255, one step per 4 cycles.
   - busy=0 once lvl=255; led_out=8'hFF continuously from then on.
2. Fade down with clamp:
   - Stimulus: from all-on, set in_port=8'h00.
   - Required: lvl steps 255->191->127->63->0, clamping at 0 with no wrap to 255.
   - busy falls when all levels are 0; led_out=0 thereafter.
3. PWM duty:
   - Stimulus: set in_port=8'h01 and stop at lvl[0]=128 by setting STEP_DIV large.
   - Required: led_out[0] is high for exactly 128 of every 256 cycles; the other bits are 0.
4. Bypass:
   - Stimulus: fade_bypass=1, change in_port 8'h00->8'hA5 at edge n.
   - Required: lvl=MAX for bits 0,2,5,7 at edge n+2; led_out=8'hA5 from edge n+3; busy is high for exactly 1 cycle.
5. Enable gating:
   - Stimulus: during a 0->MAX ramp, drop enable for 10 cycles.
   - Required: led_out=0 during those cycles while lvl keeps stepping.
   - On re-enable, the output reflects the advanced level.
6. Mid-fade reversal:
   - Stimulus: in_port bit0 1->0 when lvl[0]=128.
   - Required: the next tick gives 64 and then 0, with no jump to 255 or 0.
